// File: rtl/isp_axil_pkg.sv
// Shared AXI-Lite definitions for the ISP register file: response codes and
// the write-channel state encoding.
package isp_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

endpackage

// File: rtl/isp_axil_regfile.sv
// AXI4-Lite slave register file with RW, read-only (hardware-fed) and
// write-1-to-clear status registers plus a level interrupt.
module isp_axil_regfile
  import isp_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] evt_in,
  output logic                           irq_out
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;

  wr_state_e                            wr_state;
  logic                                 rst_done;
  logic                                 aw_held, w_held;
  logic [IDX_W-1:0]                     aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0]                w_data, w_mask, rd_val;
  logic [STRB_W-1:0]                    w_strb;
  logic                                 commit, aw_hit, ar_hit, w1c_any;
  logic [NUM_REGS-1:0]                  wr_sel;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_q;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_in;
  assign unused_in = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[LSB-1:0], s00_axi_araddr[LSB-1:0]};

  // Ready stays low until the first clock after reset has been released.
  assign s00_axi_bvalid  = (wr_state == W_RESP);
  assign s00_axi_awready = rst_done && !aw_held && !s00_axi_bvalid;
  assign s00_axi_wready  = rst_done && !w_held  && !s00_axi_bvalid;
  assign s00_axi_arready = rst_done && !s00_axi_rvalid;

  assign commit = (wr_state == W_IDLE) && aw_held && w_held;
  assign ar_idx = s00_axi_araddr[ADDR_WIDTH-1:LSB];
  assign aw_hit = {1'b0, aw_idx} < (IDX_W+1)'(NUM_REGS);
  assign ar_hit = {1'b0, ar_idx} < (IDX_W+1)'(NUM_REGS);

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < STRB_W; k++) w_mask[k*8 +: 8] = {8{w_strb[k]}};
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) wr_sel[i] = commit && (aw_idx == IDX_W'(i));
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == IDX_W'(i)) rd_val = reg_q[i];
  end

  always_comb begin
    w1c_any = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (W1C_MASK[i] && !RO_MASK[i]) w1c_any = w1c_any | (|reg_q[i]);
  end

  // Write address/data collection and response.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      rst_done      <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      wr_state      <= W_IDLE;
      s00_axi_bresp <= RESP_OKAY;
      wr_pulse      <= '0;
    end else begin
      rst_done <= 1'b1;
      wr_pulse <= '0;
      if (s00_axi_awvalid && s00_axi_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s00_axi_awaddr[ADDR_WIDTH-1:LSB];
      end
      if (s00_axi_wvalid && s00_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      case (wr_state)
        W_IDLE: if (commit) begin
          wr_state      <= W_RESP;
          s00_axi_bresp <= aw_hit ? RESP_OKAY : RESP_DECERR;
          wr_pulse      <= wr_sel & ~RO_MASK;
        end
        W_RESP: if (s00_axi_bready) begin
          wr_state <= W_IDLE;
          aw_held  <= 1'b0;
          w_held   <= 1'b0;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read channel: data captured at accept, so a same-edge write is not seen.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (s00_axi_arvalid && s00_axi_arready) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= ar_hit ? rd_val : '0;
      s00_axi_rresp  <= ar_hit ? RESP_OKAY : RESP_DECERR;
    end else if (s00_axi_rvalid && s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) irq_out <= 1'b0;
    else                  irq_out <= w1c_any;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [DATA_WIDTH-1:0] RST = RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    if (RO_MASK[i]) begin : g_ro
      assign reg_q[i] = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (W1C_MASK[i]) begin : g_w1c
      logic [DATA_WIDTH-1:0] q, clr;
      assign clr      = wr_sel[i] ? (w_data & w_mask) : '0;
      assign reg_q[i] = q;
      // Event set is applied after the clear so a coincident event survives.
      always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) q <= '0;
        else                  q <= (q & ~clr) | evt_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      assign reg_q[i] = q;
      always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) q <= RST;
        else if (wr_sel[i])   q <= (q & ~w_mask) | (w_data & w_mask);
      end
    end
  end

  assign reg_out = reg_q;

endmodule

// File: tb/tb_isp_axil_regfile.sv
// Self-checking bench for isp_axil_regfile: directed scenarios plus a
// randomized read/write sequence against an array-based register model.
module tb_isp_axil_regfile;

  localparam int DW = 32, AW = 7, NR = 16;
  localparam int RO_IDX = 7, W1C_IDX = 5, RST_IDX = 3;
  localparam logic [NR-1:0] RO_M  = 16'h0080;
  localparam logic [NR-1:0] W1C_M = 16'h0020;
  localparam logic [NR*DW-1:0] RV = (NR*DW)'(32'hCAFE_0003) << (RST_IDX*DW);

  logic clk = 1'b0, rstn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [DW-1:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] reg_out, ro_in = '0, evt_in = '0;
  logic [NR-1:0] wr_pulse;

  int tests = 0, fails = 0;
  int pulse_cnt[NR];
  logic [DW-1:0] m[NR];

  isp_axil_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VAL(RV)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .reg_out(reg_out), .wr_pulse(wr_pulse),
    .ro_in(ro_in), .evt_in(evt_in), .irq_out(irq));

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int i = 0; i < NR; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m[i] = (i == RST_IDX) ? 32'hCAFE_0003 : 32'h0;
  endfunction

  function automatic logic [1:0] model_write(int idx, logic [31:0] d, logic [3:0] s);
    logic [31:0] bm = 0;
    if (idx >= NR) return 2'b11;
    for (int k = 0; k < 4; k++) if (s[k]) bm = bm + (32'hFF << (8*k));
    if (idx == RO_IDX) return 2'b00;
    if (idx == W1C_IDX) m[idx] = m[idx] & ~(d & bm);
    else m[idx] = (m[idx] & ~bm) | (d & bm);
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_read(int idx);
    if (idx >= NR) return 0;
    if (idx == RO_IDX) return ro_in[RO_IDX*DW +: DW];
    return m[idx];
  endfunction

  function automatic logic [NR*DW-1:0] exp_out();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model_read(i);
    return v;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp, output bit ok);
    int n = 0;
    bit aa, wa;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while ((awvalid || wvalid) && n < 100) begin
      aa = awvalid && awready; wa = wvalid && wready;
      @(negedge clk); n++;
      if (aa) awvalid = 0;
      if (wa) wvalid = 0;
    end
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    resp = bresp; ok = (n < 100);
    @(negedge clk);
    bready = 0; awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
    int n = 0;
    bit acc;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 1;
    while (arvalid && n < 100) begin
      acc = arready; @(negedge clk); n++;
      if (acc) arvalid = 0;
    end
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    d = rdata; resp = rresp; ok = (n < 100);
    @(negedge clk);
    rready = 0; arvalid = 0;
  endtask

  // Presents AW and W together; returns at the negedge after both are accepted.
  task automatic send_aw_w(input logic [AW-1:0] a, input logic [31:0] d, output bit ok);
    int n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    while (!(awready && wready) && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 0; wvalid = 0; ok = (n < 100);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 0; model_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b0 || wr_pulse !== '0 ||
        bresp !== 2'b00 || rresp !== 2'b00 || rdata !== '0) begin
      fails++; $display("FAIL reset_outputs: got rdy/vld/irq=%b pulse=%h rdata=%h, need all 0",
                        {awready, wready, arready, bvalid, rvalid, irq}, wr_pulse, rdata);
    end
    tests++;
    if (reg_out !== exp_out()) begin
      fails++; $display("FAIL reset_regs: got reg3=%h reg0=%h, need reg3=cafe0003 reg0=0",
                        reg_out[RST_IDX*DW +: DW], reg_out[31:0]);
    end
    rstn = 1;
    @(negedge clk);
    tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++; $display("FAIL reset_release_ready: got %b, need 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; bit ok;
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(4*i), 32'(i+1), 4'hF, r, ok);
      void'(model_write(i, 32'(i+1), 4'hF));
      tests++;
      if (!ok || r !== 2'b00) begin fails++; $display("FAIL basic_bresp[%0d]: got %b ok=%0d, need 00", i, r, ok); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(4*i), d, r, ok);
      tests++;
      if (!ok || d !== 32'(i+1) || r !== 2'b00) begin
        fails++; $display("FAIL basic_read[%0d]: got %h/%b, need %h/00", i, d, r, i+1);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [31:0] d; bit ok; int others = 0;
    axi_write(0, 32'h1122_3344, 4'hF, r, ok); void'(model_write(0, 32'h1122_3344, 4'hF));
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
    axi_write(0, 32'hAABB_CCDD, 4'b0010, r, ok); void'(model_write(0, 32'hAABB_CCDD, 4'b0010));
    axi_read(0, d, r, ok);
    tests++;
    if (d !== 32'h1122_CC44) begin fails++; $display("FAIL strobe_read: got %h, need 1122cc44", d); end
    for (int i = 1; i < NR; i++) others += pulse_cnt[i];
    tests++;
    if (pulse_cnt[0] != 1 || others != 0) begin
      fails++; $display("FAIL strobe_pulse: got reg0 %0d cycles others %0d, need 1 and 0", pulse_cnt[0], others);
    end
  endtask

  task automatic test_order();
    logic [1:0] r; logic [31:0] d; bit ok;
    // AW three cycles ahead of W on reg 1
    @(negedge clk); awaddr = 7'h04; awvalid = 1; bready = 0;
    @(negedge clk); awvalid = 0;
    repeat (2) @(negedge clk);
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
    tests++;
    if (wready !== 1'b1) begin fails++; $display("FAIL order_wready: got %b, need 1", wready); end
    @(negedge clk); wvalid = 0;
    tests++;
    if (bvalid !== 1'b0) begin fails++; $display("FAIL order_aw_early_bvalid: got %b, need 0", bvalid); end
    @(negedge clk);
    tests++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      fails++; $display("FAIL order_aw_bvalid: got %b/%b, need 1/00", bvalid, bresp);
    end
    bready = 1; @(negedge clk); bready = 0;
    void'(model_write(1, 32'h0BAD_F00D, 4'hF));
    // W ahead of AW on reg 2
    wdata = 32'h1234_5678; wvalid = 1;
    @(negedge clk); wvalid = 0;
    repeat (2) @(negedge clk);
    awaddr = 7'h08; awvalid = 1;
    @(negedge clk); awvalid = 0;
    tests++;
    if (bvalid !== 1'b0) begin fails++; $display("FAIL order_w_early_bvalid: got %b, need 0", bvalid); end
    @(negedge clk);
    tests++;
    if (bvalid !== 1'b1) begin fails++; $display("FAIL order_w_bvalid: got %b, need 1", bvalid); end
    bready = 1; @(negedge clk); bready = 0;
    void'(model_write(2, 32'h1234_5678, 4'hF));
    for (int i = 1; i <= 2; i++) begin
      axi_read(AW'(4*i), d, r, ok);
      tests++;
      if (d !== m[i]) begin fails++; $display("FAIL order_read[%0d]: got %h, need %h", i, d, m[i]); end
    end
  endtask

  task automatic test_decerr();
    logic [1:0] r; logic [31:0] d; bit ok; logic [NR*DW-1:0] snap;
    snap = reg_out;
    axi_write(7'h40, 32'hFFFF_FFFF, 4'hF, r, ok);
    tests++;
    if (!ok || r !== 2'b11) begin fails++; $display("FAIL decerr_bresp: got %b, need 11", r); end
    axi_read(7'h40, d, r, ok);
    tests++;
    if (!ok || r !== 2'b11 || d !== 0) begin fails++; $display("FAIL decerr_read: got %h/%b, need 0/11", d, r); end
    tests++;
    if (reg_out !== snap) begin fails++; $display("FAIL decerr_regs: reg_out changed on decode error"); end
  endtask

  task automatic test_w1c();
    logic [1:0] r; logic [31:0] d; bit ok;
    @(negedge clk); evt_in[W1C_IDX*DW + 3] = 1;
    @(negedge clk); evt_in = '0; m[W1C_IDX] |= 32'h8;
    axi_read(7'h14, d, r, ok);
    tests++;
    if (d !== 32'h8 || irq !== 1'b1) begin fails++; $display("FAIL w1c_set: got %h irq=%b, need 8 irq=1", d, irq); end
    axi_write(7'h14, 32'h8, 4'hF, r, ok); void'(model_write(W1C_IDX, 32'h8, 4'hF));
    axi_read(7'h14, d, r, ok);
    tests++;
    if (d !== 32'h0 || irq !== 1'b0) begin fails++; $display("FAIL w1c_clear: got %h irq=%b, need 0 irq=0", d, irq); end
    // event lands on the same edge as the clearing write commits
    send_aw_w(7'h14, 32'h8, ok);
    evt_in[W1C_IDX*DW + 3] = 1;
    @(negedge clk); evt_in = '0;
    bready = 1; @(negedge clk); bready = 0;
    m[W1C_IDX] |= 32'h8;
    axi_read(7'h14, d, r, ok);
    tests++;
    if (!ok || d !== 32'h8) begin fails++; $display("FAIL w1c_priority: got %h, need 8", d); end
  endtask

  task automatic test_stall();
    logic [1:0] r0; logic [31:0] d0; bit ok; bit bad = 0; int n = 0;
    @(negedge clk); awaddr = 7'h0C; wdata = 32'h5A5A_0F0F; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk); awvalid = 0; wvalid = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    void'(model_write(3, 32'h5A5A_0F0F, 4'hF));
    r0 = bresp;
    repeat (10) begin
      @(negedge clk);
      if (!bvalid || bresp !== r0 || awready || wready) bad = 1;
    end
    tests++;
    if (n >= 20 || bad) begin fails++; $display("FAIL stall_write: got bvalid=%b bresp=%b aw/w ready=%b%b, need held", bvalid, bresp, awready, wready); end
    bready = 1; @(negedge clk); bready = 0;
    bad = 0; n = 0;
    ro_in[RO_IDX*DW +: DW] = 32'h7777_1111;
    araddr = 7'h1C; arvalid = 1; rready = 0;
    @(negedge clk); arvalid = 0;
    ro_in[RO_IDX*DW +: DW] = 32'h2222_3333;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    d0 = rdata;
    repeat (10) begin
      @(negedge clk);
      ro_in[RO_IDX*DW +: DW] = $urandom;
      if (!rvalid || rdata !== d0 || arready) bad = 1;
    end
    tests++;
    if (n >= 20 || bad || d0 !== 32'h7777_1111) begin
      fails++; $display("FAIL stall_read: got rdata=%h rvalid=%b arready=%b, need 77771111 held", d0, rvalid, arready);
    end
    rready = 1; @(negedge clk); rready = 0;
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    @(negedge clk); araddr = 7'h00; arvalid = 1; rready = 1;
    repeat (10) begin @(negedge clk); if (rvalid) hs++; end
    arvalid = 0;
    @(negedge clk); @(negedge clk); rready = 0;
    tests++;
    if (hs != 5) begin fails++; $display("FAIL back_to_back: got %0d reads in 10 cycles, need 5", hs); end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [31:0] d, ed, wd; logic [3:0] s; bit ok; int idx;
    int bad = 0;
    for (int t = 0; t < 60; t++) begin
      idx = $urandom_range(0, NR + 1);
      ro_in[RO_IDX*DW +: DW] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(AW'(4*idx + $urandom_range(0, 3)), wd, s, r, ok);
        er = model_write(idx, wd, s);
        if (!ok || r !== er) begin bad++; $display("FAIL random_bresp: idx %0d got %b, need %b", idx, r, er); end
      end else begin
        ed = model_read(idx); er = (idx >= NR) ? 2'b11 : 2'b00;
        axi_read(AW'(4*idx), d, r, ok);
        if (!ok || d !== ed || r !== er) begin bad++; $display("FAIL random_read: idx %0d got %h/%b, need %h/%b", idx, d, r, ed, er); end
      end
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (reg_out !== exp_out()) begin fails++; $display("FAIL random_regout: reg_out differs from model"); end
  endtask

  task automatic test_reset_mid();
    bit ok, bad = 0;
    send_aw_w(7'h0C, 32'h0000_BEEF, ok);
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1; model_reset();
    repeat (6) begin @(negedge clk); if (bvalid) bad = 1; end
    tests++;
    if (!ok || bad || reg_out !== exp_out()) begin
      fails++; $display("FAIL reset_mid: got bvalid_seen=%0d reg3=%h, need 0 and cafe0003", bad, reg_out[RST_IDX*DW +: DW]);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
    ro_in[RO_IDX*DW +: DW] = 32'hC0DE_0007;
    test_reset();
    test_basic();
    test_strobe();
    test_order();
    test_decerr();
    test_w1c();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
